// File: rtl/dcpu_pipe_core.sv
// dcpu_pipe_core: multi-cycle two-stack CPU, sole master of a single-port bus.
// Bus handshake: o_cs is the request (valid) and i_ack the completion (ready).
// While o_cs=1, o_addr/o_we/o_dat stay stable. The transfer completes on the
// first rising edge that samples i_ack=1, and read data is taken on that edge.
module dcpu_pipe_core #(
    parameter int          W       = 16,
    parameter int          DSS     = 5,
    parameter int          RSS     = 5,
    parameter int unsigned RST_VEC = 0,
    parameter int unsigned IRQ_VEC = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    output logic [W-1:0] o_addr,
    output logic [W-1:0] o_dat,
    input  logic [W-1:0] i_dat,
    input  logic         i_ack,
    output logic         o_we,
    output logic         o_cs,
    input  logic         i_irq,
    output logic         o_irq_ack,
    output logic [1:0]   o_err
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_EXEC, S_IRQ} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   pc, ir, t_q, n_q, r_q, ld_q;
    logic [DSS-1:0] dsp, dsp_nx;
    logic [RSS-1:0] rsp, rsp_nx;
    logic           ie;
    logic [1:0]     err;
    logic           dsp_err, rsp_err;

    logic [W-1:0]   dstk [2**DSS];
    logic [W-1:0]   rstk [2**RSS];

    // Instruction fields, positioned from the top bit so any W >= 16 works
    logic         is_alu, is_store, is_load;
    logic [2:0]   f_dst;
    logic [5:0]   f_alu;
    logic [1:0]   f_dsp, f_rsp;
    logic [W-1:0] mem_addr, alu_res, pc_inc;

    assign is_alu   = ir[W-1];
    assign f_dst    = ir[W-2:W-4];
    assign f_alu    = ir[W-5:W-10];
    assign f_dsp    = ir[W-11:W-12];
    assign f_rsp    = ir[W-13:W-14];
    assign is_store = is_alu && (f_dst == 3'd4 || f_dst == 3'd5);
    // A load combined with a store is executed as the store alone
    assign is_load  = is_alu && !is_store && (f_alu == 6'd11 || f_alu == 6'd12);
    assign mem_addr = (is_store ? (f_dst == 3'd5) : (f_alu == 6'd12)) ? r_q : t_q;
    assign pc_inc   = pc + 1'b1;
    assign o_err    = err;

    // ALU result from the operands latched in DECODE
    always_comb begin
        alu_res = '0;
        case (f_alu)
            6'd0:  alu_res = t_q;
            6'd1:  alu_res = n_q;
            6'd2:  alu_res = r_q;
            6'd3:  alu_res = n_q + t_q;
            6'd4:  alu_res = n_q - t_q;
            6'd5:  alu_res = n_q & t_q;
            6'd6:  alu_res = n_q | t_q;
            6'd7:  alu_res = n_q ^ t_q;
            6'd8:  alu_res = ~t_q;
            6'd9:  alu_res = t_q >> 1;
            6'd10: alu_res = t_q << 1;
            6'd11: alu_res = ld_q;
            6'd12: alu_res = ld_q;
            6'd13: alu_res = (t_q == '0) ? r_q : pc_inc;
            6'd14: alu_res = r_q;
            6'd15: alu_res = t_q;
            6'd16: alu_res = t_q;
            default: alu_res = '0;
        endcase
    end

    // Stack pointer updates for EXECUTE, with wrap detection
    always_comb begin
        dsp_nx  = dsp;
        rsp_nx  = rsp;
        dsp_err = 1'b0;
        rsp_err = 1'b0;
        if (!is_alu) begin
            dsp_nx  = dsp + 1'b1;
            dsp_err = &dsp;
        end else begin
            if (f_dsp == 2'b01) begin
                dsp_nx  = dsp + 1'b1;
                dsp_err = &dsp;
            end else if (f_dsp == 2'b10) begin
                dsp_nx  = dsp - 1'b1;
                dsp_err = (dsp == '0);
            end
            if (f_rsp == 2'b01 || f_rsp == 2'b11) begin
                rsp_nx  = rsp + 1'b1;
                rsp_err = &rsp;
            end else if (f_rsp == 2'b10) begin
                rsp_nx  = rsp - 1'b1;
                rsp_err = (rsp == '0);
            end
        end
    end

    // Stack write port selection; a PC push beats a dst=R write
    logic           ds_we, rs_we;
    logic [DSS-1:0] ds_wa;
    logic [RSS-1:0] rs_wa;
    logic [W-1:0]   ds_wd, rs_wd;

    always_comb begin
        ds_we = 1'b0;
        ds_wa = dsp_nx;
        ds_wd = alu_res;
        rs_we = 1'b0;
        rs_wa = rsp_nx;
        rs_wd = alu_res;
        if (state == S_EXEC) begin
            if (!is_alu) begin
                ds_we = 1'b1;
                ds_wd = {1'b0, ir[W-2:0]};
            end else begin
                if (f_dst == 3'd0) begin
                    ds_we = 1'b1;
                end else if (f_dst == 3'd1) begin
                    ds_we = 1'b1;
                    ds_wa = dsp_nx - 1'b1;
                end
                if (f_rsp == 2'b11) begin
                    rs_we = 1'b1;
                    rs_wd = pc_inc;
                end else if (f_dst == 3'd2) begin
                    rs_we = 1'b1;
                end
            end
        end else if (state == S_IRQ) begin
            rs_we = 1'b1;
            rs_wa = rsp + 1'b1;
            rs_wd = pc;
        end
    end

    // Stack RAM writes; contents are deliberately not reset
    always_ff @(posedge i_clk) begin
        if (ds_we) dstk[ds_wa] <= ds_wd;
        if (rs_we) rstk[rs_wa] <= rs_wd;
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_FETCH;
        else         state <= state_nx;
    end

    // Next state and bus outputs; reset forces the bus idle at once
    always_comb begin
        state_nx  = state;
        o_cs      = 1'b0;
        o_we      = 1'b0;
        o_addr    = '0;
        o_dat     = '0;
        o_irq_ack = 1'b0;
        case (state)
            S_FETCH: begin
                o_cs   = 1'b1;
                o_addr = pc;
                if (i_ack) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = (is_store || is_load) ? S_MEM : S_EXEC;
            S_MEM: begin
                o_cs   = 1'b1;
                o_addr = mem_addr;
                o_we   = is_store;
                o_dat  = is_store ? n_q : '0;
                if (i_ack) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = (i_irq && ie) ? S_IRQ : S_FETCH;
            S_IRQ: begin
                o_irq_ack = 1'b1;
                state_nx  = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
        if (i_reset) begin
            o_cs      = 1'b0;
            o_we      = 1'b0;
            o_addr    = '0;
            o_dat     = '0;
            o_irq_ack = 1'b0;
        end
    end

    // Architectural registers: PC, pointers, IE, sticky errors, operand latches
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc   <= W'(RST_VEC);
            ir   <= '0;
            dsp  <= '0;
            rsp  <= '0;
            ie   <= 1'b0;
            err  <= 2'b00;
            t_q  <= '0;
            n_q  <= '0;
            r_q  <= '0;
            ld_q <= '0;
        end else begin
            case (state)
                S_FETCH: if (i_ack) ir <= i_dat;
                S_DECODE: begin
                    t_q <= dstk[dsp];
                    n_q <= dstk[dsp - 1'b1];
                    r_q <= rstk[rsp];
                end
                S_MEM: if (i_ack && is_load) ld_q <= i_dat;
                S_EXEC: begin
                    dsp <= dsp_nx;
                    rsp <= rsp_nx;
                    pc  <= (is_alu && f_dst == 3'd3) ? alu_res : pc_inc;
                    if (dsp_err) err[0] <= 1'b1;
                    if (rsp_err) err[1] <= 1'b1;
                    if (is_alu && (f_alu == 6'd14 || f_alu == 6'd15)) ie <= 1'b1;
                    else if (is_alu && f_alu == 6'd16)                ie <= 1'b0;
                end
                S_IRQ: begin
                    rsp <= rsp + 1'b1;
                    if (&rsp) err[1] <= 1'b1;
                    pc  <= W'(IRQ_VEC);
                    ie  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcpu_pipe_core.sv
// tb_dcpu_pipe_core: bus-slave bench with an instruction-level reference model.
module tb_dcpu_pipe_core;
    localparam logic [15:0] IRQ_VEC = 16'h0002;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] o_addr, o_dat, i_dat;
    logic        i_ack = 1'b0, o_we, o_cs, i_irq = 1'b0, o_irq_ack;
    logic [1:0]  o_err;

    int vectors = 0;
    int miscompares = 0;

    // Clock
    always #5 clk = ~clk;

    dcpu_pipe_core #(.W(16), .DSS(5), .RSS(5), .RST_VEC(0), .IRQ_VEC(2)) dut (
        .i_clk(clk), .i_reset(i_reset), .o_addr(o_addr), .o_dat(o_dat),
        .i_dat(i_dat), .i_ack(i_ack), .o_we(o_we), .o_cs(o_cs),
        .i_irq(i_irq), .o_irq_ack(o_irq_ack), .o_err(o_err)
    );

    // Reference model: architectural state of the CPU
    logic [15:0] m_ds [32];
    logic [15:0] m_rs [32];
    int          m_dsp, m_rsp;
    logic [15:0] m_pc;
    logic        m_ie;
    logic [1:0]  m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int dst, input int op, input int dd, input int rd);
        return {1'b1, 3'(dst), 6'(op), 2'(dd), 2'(rd), 2'b00};
    endfunction

    function automatic logic [15:0] lit(input logic [15:0] v);
        return {1'b0, v[14:0]};
    endfunction

    // One instruction at the architectural level; returns the expected data-bus access
    task automatic model_step(input logic [15:0] ins, input logic [15:0] ld, input logic irq,
                              output logic mem, output logic [15:0] maddr, output logic mwe,
                              output logic [15:0] mdat, output logic took);
        logic [15:0] t, n, r, res;
        int dst, op, dd, rd;
        logic ie_old;
        t = m_ds[m_dsp];
        n = m_ds[(m_dsp + 31) % 32];
        r = m_rs[m_rsp];
        ie_old = m_ie;
        mem = 1'b0; maddr = '0; mwe = 1'b0; mdat = '0;
        if (!ins[15]) begin
            if (m_dsp == 31) m_err[0] = 1'b1;
            m_dsp = (m_dsp + 1) % 32;
            m_ds[m_dsp] = {1'b0, ins[14:0]};
            m_pc = m_pc + 16'd1;
        end else begin
            dst = int'(ins[14:12]); op = int'(ins[11:6]);
            dd = int'(ins[5:4]);    rd = int'(ins[3:2]);
            if (dst == 4 || dst == 5) begin
                mem = 1'b1; mwe = 1'b1; maddr = (dst == 4) ? t : r; mdat = n;
            end else if (op == 11 || op == 12) begin
                mem = 1'b1; maddr = (op == 11) ? t : r;
            end
            case (op)
                0: res = t;  1: res = n;  2: res = r;
                3: res = n + t;  4: res = n - t;  5: res = n & t;
                6: res = n | t;  7: res = n ^ t;  8: res = ~t;
                9: res = t >> 1; 10: res = t << 1;
                11, 12: res = ld;
                13: res = (t == 16'd0) ? r : m_pc + 16'd1;
                14: res = r;
                15, 16: res = t;
                default: res = 16'd0;
            endcase
            if (dd == 1) begin
                if (m_dsp == 31) m_err[0] = 1'b1;
                m_dsp = (m_dsp + 1) % 32;
            end else if (dd == 2) begin
                if (m_dsp == 0) m_err[0] = 1'b1;
                m_dsp = (m_dsp + 31) % 32;
            end
            if (rd == 1 || rd == 3) begin
                if (m_rsp == 31) m_err[1] = 1'b1;
                m_rsp = (m_rsp + 1) % 32;
            end else if (rd == 2) begin
                if (m_rsp == 0) m_err[1] = 1'b1;
                m_rsp = (m_rsp + 31) % 32;
            end
            if (dst == 0)      m_ds[m_dsp] = res;
            else if (dst == 1) m_ds[(m_dsp + 31) % 32] = res;
            if (rd == 3)       m_rs[m_rsp] = m_pc + 16'd1;
            else if (dst == 2) m_rs[m_rsp] = res;
            if (op == 14 || op == 15) m_ie = 1'b1;
            else if (op == 16)        m_ie = 1'b0;
            m_pc = (dst == 3) ? res : m_pc + 16'd1;
        end
        took = irq && ie_old;
        if (took) begin
            if (m_rsp == 31) m_err[1] = 1'b1;
            m_rsp = (m_rsp + 1) % 32;
            m_rs[m_rsp] = m_pc;
            m_pc = IRQ_VEC;
            m_ie = 1'b0;
        end
    endtask

    // Driver: serve one instruction from FETCH through to the next FETCH
    task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                             input logic [15:0] ld, input logic irq);
        logic mem, mwe, took;
        logic [15:0] maddr, mdat, pc0;
        pc0 = m_pc;
        model_step(ins, ld, irq, mem, maddr, mwe, mdat, took);
        i_irq = irq;
        for (int k = 0; k <= fw; k++) begin
            check("fetch_cs", 32'(o_cs), 32'd1);
            check("fetch_we", 32'(o_we), 32'd0);
            check("fetch_addr", 32'(o_addr), 32'(pc0));
            i_ack = (k == fw);
            i_dat = (k == fw) ? ins : 16'($urandom);
            @(posedge clk); @(negedge clk);
        end
        i_ack = 1'b0;
        i_dat = 16'($urandom);
        check("decode_cs", 32'(o_cs), 32'd0);
        @(posedge clk); @(negedge clk);
        if (mem) begin
            for (int k = 0; k <= mw; k++) begin
                check("mem_cs", 32'(o_cs), 32'd1);
                check("mem_we", 32'(o_we), 32'(mwe));
                check("mem_addr", 32'(o_addr), 32'(maddr));
                if (mwe) check("mem_dat", 32'(o_dat), 32'(mdat));
                i_ack = (k == mw);
                i_dat = (k == mw) ? ld : 16'($urandom);
                @(posedge clk); @(negedge clk);
            end
            i_ack = 1'b0;
        end
        check("exec_cs", 32'(o_cs), 32'd0);
        check("exec_irq_ack", 32'(o_irq_ack), 32'd0);
        @(posedge clk); @(negedge clk);
        if (took) begin
            check("irq_ack_pulse", 32'(o_irq_ack), 32'd1);
            check("irq_cs", 32'(o_cs), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        check("next_irq_ack", 32'(o_irq_ack), 32'd0);
        check("next_cs", 32'(o_cs), 32'd1);
        check("next_pc", 32'(o_addr), 32'(m_pc));
        check("err_flags", 32'(o_err), 32'(m_err));
    endtask

    task automatic model_reset();
        m_pc = 16'd0; m_dsp = 0; m_rsp = 0; m_ie = 1'b0; m_err = 2'b00;
    endtask

    // Reset sequence with checks of the idle outputs while reset is held
    task automatic do_reset();
        i_reset = 1'b1; i_ack = 1'b0; i_irq = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_cs", 32'(o_cs), 32'd0);
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_irq_ack", 32'(o_irq_ack), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_dat", 32'(o_dat), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        i_reset = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        logic [15:0] ins;
        int dst, op, dd, rd;

        do_reset();

        // Literals and addition, then jump to T to expose the sum
        run_instr(lit(16'h0005), 0, 0, 16'h0, 1'b0);
        run_instr(lit(16'h0003), 0, 0, 16'h0, 1'b0);
        run_instr(enc(0, 3, 2, 0), 0, 0, 16'h0, 1'b0);
        check("add_pc", 32'(o_addr), 32'h0003);
        run_instr(enc(3, 0, 0, 0), 0, 0, 16'h0, 1'b0);
        check("add_result", 32'(o_addr), 32'h0008);

        // Store 0xBEEF to 0x0100 with two wait states
        run_instr(lit(16'h4110), 0, 0, 16'h0, 1'b0);
        run_instr(enc(0, 8, 0, 0), 1, 0, 16'h0, 1'b0);
        run_instr(lit(16'h0100), 0, 0, 16'h0, 1'b0);
        run_instr(enc(4, 0, 2, 0), 0, 2, 16'h0, 1'b0);

        // Load from 0x0040 returning 0x1234, jump to T to expose it
        run_instr(lit(16'h0040), 0, 0, 16'h0, 1'b0);
        run_instr(enc(0, 11, 0, 0), 0, 1, 16'h1234, 1'b0);
        run_instr(enc(3, 0, 0, 0), 0, 0, 16'h0, 1'b0);
        check("load_result", 32'(o_addr), 32'h1234);

        // JZ taken and not taken, with R=0x0020
        run_instr(lit(16'h0020), 0, 0, 16'h0, 1'b0);
        run_instr(enc(2, 0, 2, 1), 0, 0, 16'h0, 1'b0);
        run_instr(lit(16'h0000), 0, 0, 16'h0, 1'b0);
        run_instr(enc(3, 13, 2, 0), 0, 0, 16'h0, 1'b0);
        check("jz_taken", 32'(o_addr), 32'h0020);
        run_instr(lit(16'h0001), 0, 0, 16'h0, 1'b0);
        run_instr(enc(3, 13, 2, 0), 0, 0, 16'h0, 1'b0);
        check("jz_not_taken", 32'(o_addr), 32'h0022);

        // Interrupt entry, masking inside the handler, RETI and re-entry
        run_instr(enc(6, 15, 0, 0), 0, 0, 16'h0, 1'b0);
        run_instr(lit(16'h0007), 1, 0, 16'h0, 1'b1);
        check("irq_vector", 32'(o_addr), 32'(IRQ_VEC));
        run_instr(lit(16'h0009), 0, 0, 16'h0, 1'b1);
        check("irq_masked", 32'(o_addr), 32'h0003);
        run_instr(enc(3, 14, 0, 2), 0, 0, 16'h0, 1'b1);
        check("reti_return", 32'(o_addr), 32'h0024);
        run_instr(lit(16'h0001), 0, 0, 16'h0, 1'b1);
        check("irq_reentry", 32'(o_addr), 32'(IRQ_VEC));
        run_instr(enc(3, 14, 0, 2), 0, 0, 16'h0, 1'b0);
        check("reti_return2", 32'(o_addr), 32'h0025);
        run_instr(enc(6, 16, 0, 0), 0, 0, 16'h0, 1'b0);

        // Randomised phase: fill both stacks, then random ops kept in the filled region
        do_reset();
        for (int i = 0; i < 20; i++)
            run_instr(lit(16'($urandom)), $urandom_range(0, 1), 0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            run_instr(lit(16'($urandom)), 0, 0, 16'h0, 1'b0);
            run_instr(enc(2, 0, 2, 1), 0, 0, 16'h0, 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0 && m_dsp < 20) begin
                ins = lit(16'($urandom));
            end else begin
                dst = $urandom_range(0, 7);
                op  = $urandom_range(0, 18);
                if ($urandom_range(0, 9) == 0) op = 63;
                dd  = $urandom_range(0, 3);
                rd  = $urandom_range(0, 3);
                if (dd == 1 && m_dsp >= 20) dd = 0;
                if (dd == 2 && m_dsp <= 2) dd = 0;
                if ((rd == 1 || rd == 3) && m_rsp >= 20) rd = 0;
                if (rd == 2 && m_rsp <= 1) rd = 0;
                ins = enc(dst, op, dd, rd);
            end
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), 16'($urandom), 1'b0);
        end

        // Data stack overflow: 33 pushes from an empty stack
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            run_instr(lit(16'(k)), 0, 0, 16'h0, 1'b0);
            check("ovf_flag", 32'(o_err[0]), (k >= 32) ? 32'd1 : 32'd0);
        end

        // Reset in the middle of a fetch, with an ack arriving during reset
        check("prerst_cs", 32'(o_cs), 32'd1);
        #1 i_reset = 1'b1;
        #1;
        check("midrst_cs", 32'(o_cs), 32'd0);
        check("midrst_err", 32'(o_err), 32'd0);
        i_ack = 1'b1;
        i_dat = lit(16'h0011);
        @(posedge clk); @(negedge clk);
        i_ack = 1'b0;
        i_reset = 1'b0;
        model_reset();
        #1;
        check("postrst_cs", 32'(o_cs), 32'd1);
        check("postrst_addr", 32'(o_addr), 32'd0);

        // Underflow of the return stack, then of the data stack
        run_instr(enc(6, 0, 0, 2), 0, 0, 16'h0, 1'b0);
        check("rstk_underflow", 32'(o_err), 32'd2);
        run_instr(enc(6, 0, 2, 0), 0, 0, 16'h0, 1'b0);
        check("dstk_underflow", 32'(o_err), 32'd3);

        // Report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcpu_pipe_core.md
Name: dcpu_pipe_core

Overview:
Parametrised successor of the 16-bit two-phase stack CPU. Configurable data width, stack depths and reset/interrupt vectors. Adds a wait-stated data-memory phase, vectored interrupts with an enable flag, and sticky stack overflow/underflow detection. Sits as the sole bus master in front of the shared single-port memory.

Parameters:
W, 16, data/instruction width; must be at least 16
DSS, 5, data stack depth = 2^DSS entries
RSS, 5, return stack depth = 2^RSS entries
RST_VEC, 0, PC value after reset
IRQ_VEC, 2, PC loaded on interrupt entry

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_reset  in  1  asynchronous, active-high reset
o_addr  out  W  bus address
o_dat  out  W  write data
i_dat  in  W  read data; valid when i_ack=1
i_ack  in  1  bus cycle complete
o_we  out  1  write strobe; qualified by o_cs
o_cs  out  1  bus request; held until i_ack
i_irq  in  1  level-sensitive interrupt request
o_irq_ack  out  1  one-cycle pulse on interrupt entry
o_err  out  2  sticky flags: [0] dstack over/underflow, [1] rstack over/underflow

Behaviour:
- Reset (asynchronous): state=FETCH, PC=RST_VEC, dsp=0, rsp=0, IE=0, o_err=0. Outputs o_cs=0, o_we=0, o_irq_ack=0, o_addr=0, o_dat=0 while reset is asserted. Stack RAM contents are not reset.
- Instruction format (field positions relative to W-1):
  - Bit W-1 = 0: literal. Push zero-extended bits [W-2:0]; dsp+1.
  - Bit W-1 = 1: dst[3] at W-2..W-4, alu[6] at W-5..W-10, dsp[2] at W-11..W-12, rsp[2] at W-13..W-14. Remaining bits are ignored.
- dst codes: 0=T, 1=N, 2=R, 3=PC, 4=mem[T] write, 5=mem[R] write, 6/7=none.
- ALU ops (result is W bits):
  - 0 T; 1 N; 2 R; 3 N+T; 4 N-T; 5 N&T; 6 N|T; 7 N^T; 8 ~T
  - 9 T>>1 (logical); 10 T<<1
  - 11 load mem[T]; 12 load mem[R]
  - 13 JZ: result is R if T==0, else PC+1
  - 14 RETI: result is R, and sets IE=1
  - 15 EI: sets IE=1, result T; 16 DI: sets IE=0, result T
  - other codes: result 0
- dsp codes: 01=+1, 10=-1, else hold. rsp codes: 01=+1, 10=-1, 11=push PC+1 (+1), 00=hold.
- State machine:
  - FETCH: o_cs=1, o_addr=PC. On i_ack, latch the instruction and go to DECODE. With no ack, hold indefinitely.
  - DECODE: T, N and R are read from the stacks. Go to MEM if the instruction is a load or a memory write, else EXECUTE.
  - MEM: o_cs=1. Address is T (dst 4 or alu 11) or R (dst 5 or alu 12). o_we=1 for writes, with o_dat=N. On i_ack, capture i_dat for loads and go to EXECUTE.
  - EXECUTE: commit the destination, dsp, rsp and PC. PC is the ALU result if dst=3, else PC+1. Next state is IRQ if i_irq=1 && IE=1, else FETCH.
  - IRQ: push PC to the rstack (rsp+1), PC=IRQ_VEC, IE=0, o_irq_ack=1 for this cycle only, then go to FETCH.
- Latency with zero wait states: 3 cycles for non-memory instructions, 4 for memory instructions. Each bus wait cycle adds 1.
- A combined load+store instruction is illegal: it executes as a store only.
- Pointer wrap-around is modular. Stack errors:
  - dsp+1 from 2^DSS-1 sets o_err[0]; dsp-1 from 0 sets o_err[0].
  - rsp wrap in either direction sets o_err[1] in the same way.
  - Flags clear only on reset.
- Simultaneous dst=R and rsp=11: the PC push wins.
- An interrupt is never taken mid-instruction. An irq arriving during FETCH or MEM waits for EXECUTE.
- Reset asserted mid-bus-cycle drops o_cs immediately. An ack arriving after reset is ignored.

Test Plan:
- Reset then literals 0x0005, 0x0003, then ALU op 3 (N+T) with dsp -1 -> T=0x0008, dsp=1, PC=3. Each instruction takes 3 cycles with i_ack tied high.
- Store with T=0x0100, N=0xBEEF, 2 wait states -> MEM state shows o_we=1, o_addr=0x0100, o_dat=0xBEEF for 3 cycles. Next fetch follows after EXECUTE.
- Load from [T]=0x0040 with memory returning 0x1234 -> T=0x1234. PC advances by 1.
- JZ with T=0 and R=0x0020 -> next fetch address is 0x0020. The same instruction with T=1 -> next fetch address is PC+1.
- Execute EI, then raise i_irq during the next fetch -> after EXECUTE: o_irq_ack pulses, PC=0x0002, rstack top holds the return PC, IE=0. RETI returns to the saved PC and sets IE=1.
- 33 literal pushes with DSS=5 -> o_err[0] goes to 1 on the 32nd push (dsp wraps from 31 to 0) and stays set. Asserting i_reset mid-FETCH -> o_cs=0 immediately, and o_err=0 after reset.
